obstacle_lane_scheduler: RTL and testbench

Configures and sequences a bank of NUM_LANES obstacle movers.
- Assigns each lane its spawn X/Y, speed and direction, and pulses a per-lane reload so the mover restarts at the new spawn point.
- Activates lanes one at a time on a frame-based schedule.
- Raises difficulty (level) on a timer or on an external request.
- Sits between the game-state FSM and the obstacle mover instances.

---
 rtl/game_pkg.sv | 30 +++
 rtl/lfsr16.sv | 24 ++
 rtl/obstacle_lane_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_obstacle_lane_scheduler.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-level definitions: game-state codes, screen geometry and the
// lane scheduler state encoding.
package game_pkg;

    localparam logic [1:0] GS_MENU  = 2'b00;
    localparam logic [1:0] GS_PLAY  = 2'b01;
    localparam logic [1:0] GS_PAUSE = 2'b10;
    localparam logic [1:0] GS_OVER  = 2'b11;

    localparam int SCREEN_WIDTH = 640;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONFIG   = 2'd1,
        RUN      = 2'd2,
        LEVEL_UP = 2'd3
    } sched_state_t;

    // Fold a 10-bit random value onto the visible screen width.
    function automatic logic [9:0] wrap_spawn_x(input logic [9:0] r);
        logic [9:0] w;
        if (r < 10'(SCREEN_WIDTH)) begin
            w = r;
        end else begin
            w = r - 10'(SCREEN_WIDTH);
        end
        return w;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (taps 0xB400), seeded with 0xACE1 on reset.
module lfsr16 (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] q_r;

    // Shift register; the feedback bit is XORed into the tap positions.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            q_r <= 16'hACE1;
        end else if (en) begin
            q_r <= {1'b0, q_r[15:1]} ^ (q_r[0] ? 16'hB400 : 16'h0000);
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/obstacle_lane_scheduler.sv
// Configures obstacle lanes (spawn point, speed, direction), activates them on
// a frame schedule and raises the difficulty level.
module obstacle_lane_scheduler
    import game_pkg::*;
#(
    parameter int NUM_LANES      = 8,
    parameter int TOP_Y          = 64,
    parameter int LANE_HEIGHT    = 32,
    parameter int SPAWN_INTERVAL = 30,
    parameter int LEVEL_FRAMES   = 600,
    parameter int BASE_SPEED     = 1,
    parameter int MAX_SPEED      = 12
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [1:0]              gameState,
    input  logic                    frame_start,
    input  logic                    level_up_req,
    output logic [NUM_LANES*10-1:0] spawnX,
    output logic [NUM_LANES*9-1:0]  spawnY,
    output logic [NUM_LANES*4-1:0]  speed,
    output logic [NUM_LANES-1:0]    direction,
    output logic [NUM_LANES-1:0]    active,
    output logic [NUM_LANES-1:0]    obstacle_reset,
    output logic [3:0]              level
);

    localparam int KW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int SW = $clog2(SPAWN_INTERVAL + 1);
    localparam int LW = $clog2(LEVEL_FRAMES + 1);
    localparam logic [KW-1:0]        LAST_LANE  = KW'(NUM_LANES - 1);
    localparam logic [SW-1:0]        SPAWN_WRAP = SW'(SPAWN_INTERVAL - 1);
    localparam logic [LW-1:0]        LEVEL_WRAP = LW'(LEVEL_FRAMES - 1);
    localparam logic [NUM_LANES-1:0] LANE_ONE   = NUM_LANES'(1);

    sched_state_t           state_r, state_s;
    logic [KW-1:0]          k_r, k_s;
    logic [SW-1:0]          spawn_cnt_r, spawn_cnt_s;
    logic [LW-1:0]          lvl_cnt_r, lvl_cnt_s;
    logic [3:0]             level_r, level_s;
    logic                   pend_lvl_r, pend_lvl_s;
    logic [NUM_LANES-1:0]   reload_pend_r, reload_pend_s;
    logic [NUM_LANES*10-1:0] spawn_x_r, spawn_x_s;
    logic [NUM_LANES*9-1:0] spawn_y_r, spawn_y_s;
    logic [NUM_LANES*4-1:0] speed_r, speed_s;
    logic [NUM_LANES-1:0]   direction_r, direction_s;
    logic [NUM_LANES-1:0]   active_r, active_s;
    logic [NUM_LANES-1:0]   obstacle_reset_r, obstacle_reset_s;

    logic [15:0]            lfsr_q_s;
    logic                   unused_lfsr_s;
    logic                   frozen_s;
    logic                   lvl_wrap_s;
    logic [NUM_LANES-1:0]   first_free_s;
    logic [9:0]             lane_x_s;
    logic [8:0]             lane_y_s;
    logic [4:0]             raw_speed_s;
    logic [3:0]             lane_speed_s;

    lfsr16 u_lfsr (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .en       (1'b1),
        .q        (lfsr_q_s)
    );

    assign unused_lfsr_s = ^lfsr_q_s[15:10];

    // Per-lane values for the lane currently being configured.
    assign lane_x_s     = wrap_spawn_x(lfsr_q_s[9:0]);
    assign lane_y_s     = 9'(TOP_Y + LANE_HEIGHT * int'(k_r));
    assign raw_speed_s  = 5'(BASE_SPEED) + {1'b0, level_r} + 5'(int'(k_r) % 3);
    assign lane_speed_s = (raw_speed_s > 5'(MAX_SPEED)) ? 4'(MAX_SPEED) : raw_speed_s[3:0];
    // Lanes only ever switch on in index order, so the lowest zero bit is the next lane.
    assign first_free_s = ~active_r & (active_r + LANE_ONE);
    assign frozen_s     = (state_r != IDLE) && ((gameState == GS_PAUSE) || (gameState == GS_OVER));

    // Next-state and next-output logic for the scheduler.
    always_comb begin
        state_s          = state_r;
        k_s              = k_r;
        spawn_cnt_s      = spawn_cnt_r;
        lvl_cnt_s        = lvl_cnt_r;
        level_s          = level_r;
        pend_lvl_s       = pend_lvl_r;
        reload_pend_s    = '0;
        spawn_x_s        = spawn_x_r;
        spawn_y_s        = spawn_y_r;
        speed_s          = speed_r;
        direction_s      = direction_r;
        active_s         = active_r;
        obstacle_reset_s = reload_pend_r;
        lvl_wrap_s       = 1'b0;

        if (frozen_s) begin
            // Hold the due reload so it fires once play resumes.
            reload_pend_s    = reload_pend_r;
            obstacle_reset_s = '0;
        end else if ((state_r != IDLE) && (gameState == GS_MENU)) begin
            state_s    = IDLE;
            active_s   = '0;
            level_s    = 4'd0;
            pend_lvl_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    active_s = '0;
                    if (gameState == GS_PLAY) begin
                        state_s = CONFIG;
                        k_s     = '0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                CONFIG: begin
                    spawn_x_s[int'(k_r)*10 +: 10] = lane_x_s;
                    spawn_y_s[int'(k_r)*9 +: 9]   = lane_y_s;
                    speed_s[int'(k_r)*4 +: 4]     = lane_speed_s;
                    direction_s[k_r]              = k_r[0];
                    active_s[k_r]                 = 1'b0;
                    reload_pend_s[k_r]            = 1'b1;
                    pend_lvl_s                    = pend_lvl_r | level_up_req;
                    if (k_r == LAST_LANE) begin
                        state_s     = RUN;
                        spawn_cnt_s = '0;
                        lvl_cnt_s   = '0;
                    end else begin
                        k_s = k_r + KW'(1);
                    end
                end
                RUN: begin
                    if (frame_start) begin
                        if ((spawn_cnt_r == SPAWN_WRAP) || (active_r == '0)) begin
                            spawn_cnt_s = '0;
                            active_s    = active_r | first_free_s;
                        end else begin
                            spawn_cnt_s = spawn_cnt_r + SW'(1);
                        end
                        if (lvl_cnt_r == LEVEL_WRAP) begin
                            lvl_cnt_s  = '0;
                            lvl_wrap_s = 1'b1;
                        end else begin
                            lvl_cnt_s = lvl_cnt_r + LW'(1);
                        end
                    end else begin
                        spawn_cnt_s = spawn_cnt_r;
                    end
                    if (level_up_req || pend_lvl_r || lvl_wrap_s) begin
                        state_s = LEVEL_UP;
                    end else begin
                        state_s = RUN;
                    end
                end
                LEVEL_UP: begin
                    level_s    = (level_r == 4'd15) ? 4'd15 : level_r + 4'd1;
                    pend_lvl_s = level_up_req;
                    active_s   = '0;
                    state_s    = CONFIG;
                    k_s        = '0;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r          <= IDLE;
            k_r              <= '0;
            spawn_cnt_r      <= '0;
            lvl_cnt_r        <= '0;
            level_r          <= 4'd0;
            pend_lvl_r       <= 1'b0;
            reload_pend_r    <= '0;
            spawn_x_r        <= '0;
            spawn_y_r        <= '0;
            speed_r          <= '0;
            direction_r      <= '0;
            active_r         <= '0;
            obstacle_reset_r <= '0;
        end else begin
            state_r          <= state_s;
            k_r              <= k_s;
            spawn_cnt_r      <= spawn_cnt_s;
            lvl_cnt_r        <= lvl_cnt_s;
            level_r          <= level_s;
            pend_lvl_r       <= pend_lvl_s;
            reload_pend_r    <= reload_pend_s;
            spawn_x_r        <= spawn_x_s;
            spawn_y_r        <= spawn_y_s;
            speed_r          <= speed_s;
            direction_r      <= direction_s;
            active_r         <= active_s;
            obstacle_reset_r <= obstacle_reset_s;
        end
    end

    assign spawnX         = spawn_x_r;
    assign spawnY         = spawn_y_r;
    assign speed          = speed_r;
    assign direction      = direction_r;
    assign active         = active_r;
    assign obstacle_reset = obstacle_reset_r;
    assign level          = level_r;

endmodule

// File: tb/tb_obstacle_lane_scheduler.sv
// Self-checking bench for obstacle_lane_scheduler: directed scenarios plus
// random play, compared against a lane-level behavioural model.
module tb_obstacle_lane_scheduler;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  gameState = 2'b00;
    logic        frame_start = 1'b0;
    logic        level_up_req = 1'b0;
    logic [79:0] spawnX;
    logic [71:0] spawnY;
    logic [31:0] speed;
    logic [7:0]  direction;
    logic [7:0]  active;
    logic [7:0]  obstacle_reset;
    logic [3:0]  level;
    logic [211:0] dut_bundle;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: phase 0 idle, 1 configuring, 2 running, 3 levelling up
    int          m_ph = 0;
    int          m_k = 0;
    int          m_scnt = 0;
    int          m_fcnt = 0;
    int          m_level = 0;
    bit          m_pend = 1'b0;
    int unsigned m_lfsr = 32'hACE1;
    int          m_sx[8];
    int          m_sy[8];
    int          m_spd[8];
    bit [7:0]    m_dir = 8'd0;
    bit [7:0]    m_act = 8'd0;
    bit [7:0]    m_or = 8'd0;
    bit [7:0]    m_due = 8'd0;

    obstacle_lane_scheduler #(
        .NUM_LANES(8), .TOP_Y(64), .LANE_HEIGHT(32), .SPAWN_INTERVAL(30),
        .LEVEL_FRAMES(600), .BASE_SPEED(1), .MAX_SPEED(12)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .gameState      (gameState),
        .frame_start    (frame_start),
        .level_up_req   (level_up_req),
        .spawnX         (spawnX),
        .spawnY         (spawnY),
        .speed          (speed),
        .direction      (direction),
        .active         (active),
        .obstacle_reset (obstacle_reset),
        .level          (level)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    assign dut_bundle = {spawnX, spawnY, speed, direction, active, obstacle_reset, level};

    task automatic model_update();
        int unsigned old_lfsr;
        int unsigned r;
        int lane;
        bit wrap;
        if (reset) begin
            m_ph = 0; m_k = 0; m_scnt = 0; m_fcnt = 0; m_level = 0; m_pend = 1'b0;
            m_lfsr = 32'hACE1; m_dir = 8'd0; m_act = 8'd0; m_or = 8'd0; m_due = 8'd0;
            for (int i = 0; i < 8; i++) begin
                m_sx[i] = 0; m_sy[i] = 0; m_spd[i] = 0;
            end
            return;
        end
        old_lfsr = m_lfsr;
        m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 32'd1) != 32'd0) ? 32'hB400 : 32'h0);
        if (m_ph != 0 && (gameState == 2'b10 || gameState == 2'b11)) begin
            m_or = 8'd0;
            return;
        end
        m_or = m_due;
        m_due = 8'd0;
        if (m_ph != 0 && gameState == 2'b00) begin
            m_ph = 0; m_act = 8'd0; m_level = 0; m_pend = 1'b0;
            return;
        end
        case (m_ph)
            0: begin
                m_act = 8'd0;
                if (gameState == 2'b01) begin m_ph = 1; m_k = 0; end
            end
            1: begin
                r = old_lfsr % 1024;
                m_sx[m_k] = (r < 640) ? int'(r) : int'(r) - 640;
                m_sy[m_k] = (64 + 32 * m_k) % 512;
                m_spd[m_k] = (1 + m_level + m_k % 3 > 12) ? 12 : 1 + m_level + m_k % 3;
                m_dir[m_k] = (m_k % 2) == 1;
                m_act[m_k] = 1'b0;
                m_due = 8'd1 << m_k;
                if (level_up_req) m_pend = 1'b1;
                if (m_k == 7) begin m_ph = 2; m_scnt = 0; m_fcnt = 0; end
                else m_k++;
            end
            2: begin
                wrap = 1'b0;
                if (frame_start) begin
                    if (m_act == 8'd0 || m_scnt == 29) begin
                        m_scnt = 0;
                        lane = -1;
                        for (int i = 7; i >= 0; i--) if (!m_act[i]) lane = i;
                        if (lane >= 0) m_act[lane] = 1'b1;
                    end else begin
                        m_scnt++;
                    end
                    if (m_fcnt == 599) begin m_fcnt = 0; wrap = 1'b1; end
                    else m_fcnt++;
                end
                if (level_up_req || m_pend || wrap) m_ph = 3;
            end
            default: begin
                m_level = (m_level >= 15) ? 15 : m_level + 1;
                m_pend = level_up_req;
                m_act = 8'd0;
                m_ph = 1;
                m_k = 0;
            end
        endcase
    endtask

    function automatic logic [211:0] expected_bundle();
        logic [79:0] sx;
        logic [71:0] sy;
        logic [31:0] sp;
        for (int i = 0; i < 8; i++) begin
            sx[i*10 +: 10] = 10'(m_sx[i]);
            sy[i*9 +: 9]   = 9'(m_sy[i]);
            sp[i*4 +: 4]   = 4'(m_spd[i]);
        end
        return {sx, sy, sp, m_dir, m_act, m_or, 4'(m_level)};
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        gameState = 2'($urandom_range(0, 3));
        frame_start = 1'($urandom_range(0, 1));
        level_up_req = 1'($urandom_range(0, 1));
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (dut_bundle !== 212'd0) begin
            miscompares++; $display("FAIL reset_zero: got %h want 0", dut_bundle);
        end
        reset = 1'b0; gameState = 2'b00; frame_start = 1'b0; level_up_req = 1'b0;
        tick();
        vectors++;
        if (dut_bundle !== expected_bundle()) begin
            miscompares++; $display("FAIL reset_idle: got %h want %h", dut_bundle, expected_bundle());
        end
    endtask

    task automatic test_config();
        logic [7:0] exp_or;
        gameState = 2'b01;
        for (int t = 1; t <= 12; t++) begin
            tick();
            vectors++;
            if (dut_bundle !== expected_bundle()) begin
                miscompares++; $display("FAIL config_model t=%0d: got %h want %h", t, dut_bundle, expected_bundle());
            end
            exp_or = (t >= 3 && t <= 10) ? (8'd1 << (t - 3)) : 8'd0;
            vectors++;
            if (obstacle_reset !== exp_or) begin
                miscompares++; $display("FAIL config_reload t=%0d: got %h want %h", t, obstacle_reset, exp_or);
            end
        end
        vectors++;
        if (spawnY[27 +: 9] !== 9'd160 || speed[12 +: 4] !== 4'd1 || direction[3] !== 1'b1) begin
            miscompares++; $display("FAIL lane3_cfg: got y=%0d spd=%0d dir=%b want 160 1 1", spawnY[27 +: 9], speed[12 +: 4], direction[3]);
        end
        vectors++;
        if (speed[20 +: 4] !== 4'd3) begin
            miscompares++; $display("FAIL lane5_speed: got %0d want 3", speed[20 +: 4]);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (spawnX[i*10 +: 10] >= 10'd640) begin
                miscompares++; $display("FAIL spawnx_range lane %0d: got %0d want <640", i, spawnX[i*10 +: 10]);
            end
        end
    endtask

    task automatic test_run_spawn();
        logic [7:0] exp_act;
        for (int f = 1; f <= 270; f++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            vectors++;
            if (dut_bundle !== expected_bundle()) begin
                miscompares++; $display("FAIL run_model f=%0d: got %h want %h", f, dut_bundle, expected_bundle());
            end
            if (f == 1 || f == 30 || f == 31 || f == 240 || f == 270) begin
                exp_act = (f <= 30) ? 8'h01 : ((f == 31) ? 8'h03 : 8'hFF);
                vectors++;
                if (active !== exp_act) begin
                    miscompares++; $display("FAIL run_active f=%0d: got %h want %h", f, active, exp_act);
                end
            end
            repeat (3) tick();
        end
    endtask

    task automatic test_level_up();
        int cnt[8];
        level_up_req = 1'b1;
        tick();
        level_up_req = 1'b0;
        tick();
        vectors++;
        if (level !== 4'd1 || active !== 8'h00) begin
            miscompares++; $display("FAIL levelup_state: got level=%0d active=%h want 1 00", level, active);
        end
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            vectors++;
            if (dut_bundle !== expected_bundle()) begin
                miscompares++; $display("FAIL levelup_model t=%0d: got %h want %h", t, dut_bundle, expected_bundle());
            end
            for (int i = 0; i < 8; i++) if (obstacle_reset[i]) cnt[i]++;
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (cnt[i] != 1) begin
                miscompares++; $display("FAIL levelup_reload lane %0d: got %0d pulses want 1", i, cnt[i]);
            end
        end
        vectors++;
        if (speed[8 +: 4] !== 4'd4) begin
            miscompares++; $display("FAIL lane2_speed_l1: got %0d want 4", speed[8 +: 4]);
        end
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 18; r++) begin
            level_up_req = 1'b1;
            tick();
            level_up_req = 1'b0;
            for (int t = 0; t < 12; t++) begin
                tick();
                vectors++;
                if (dut_bundle !== expected_bundle()) begin
                    miscompares++; $display("FAIL sat_model r=%0d: got %h want %h", r, dut_bundle, expected_bundle());
                end
            end
        end
        vectors++;
        if (level !== 4'd15 || speed !== 32'hCCCC_CCCC) begin
            miscompares++; $display("FAIL saturation: got level=%0d speed=%h want 15 cccccccc", level, speed);
        end
    endtask

    task automatic test_pause();
        logic [7:0] exp_act;
        for (int f = 1; f <= 40; f++) begin
            frame_start = 1'b1; tick(); frame_start = 1'b0; repeat (3) tick();
        end
        gameState = 2'b10;
        for (int f = 1; f <= 100; f++) begin
            frame_start = 1'b1; tick(); frame_start = 1'b0;
            vectors++;
            if (active !== 8'h03 || obstacle_reset !== 8'h00 || dut_bundle !== expected_bundle()) begin
                miscompares++; $display("FAIL pause_hold f=%0d: got %h want %h", f, dut_bundle, expected_bundle());
            end
            repeat (3) tick();
        end
        gameState = 2'b01;
        for (int f = 1; f <= 21; f++) begin
            frame_start = 1'b1; tick(); frame_start = 1'b0;
            if (f >= 20) begin
                exp_act = (f == 20) ? 8'h03 : 8'h07;
                vectors++;
                if (active !== exp_act) begin
                    miscompares++; $display("FAIL pause_resume f=%0d: got %h want %h", f, active, exp_act);
                end
            end
            repeat (3) tick();
        end
        gameState = 2'b00;
        tick();
        vectors++;
        if (level !== 4'd0 || active !== 8'h00) begin
            miscompares++; $display("FAIL menu_return: got level=%0d active=%h want 0 00", level, active);
        end
    endtask

    task automatic test_simultaneous();
        gameState = 2'b01;
        repeat (10) tick();
        for (int f = 1; f <= 600; f++) begin
            frame_start = 1'b1;
            level_up_req = (f == 600);
            tick();
            frame_start = 1'b0; level_up_req = 1'b0;
            if (f == 599) begin
                vectors++;
                if (level !== 4'd0) begin
                    miscompares++; $display("FAIL wrap_early: got level=%0d want 0", level);
                end
            end
            repeat (3) tick();
        end
        repeat (12) tick();
        vectors++;
        if (level !== 4'd1 || dut_bundle !== expected_bundle()) begin
            miscompares++; $display("FAIL wrap_and_req: got level=%0d want 1", level);
        end
        gameState = 2'b00; tick();
        gameState = 2'b01; tick();
        repeat (4) tick();
        level_up_req = 1'b1; tick(); level_up_req = 1'b0;
        repeat (4) tick();
        vectors++;
        if (level !== 4'd0) begin
            miscompares++; $display("FAIL cfg_req_early: got level=%0d want 0", level);
        end
        tick();
        vectors++;
        if (level !== 4'd1) begin
            miscompares++; $display("FAIL cfg_req_level: got level=%0d want 1", level);
        end
        repeat (20) tick();
        vectors++;
        if (level !== 4'd1 || dut_bundle !== expected_bundle()) begin
            miscompares++; $display("FAIL cfg_req_single: got level=%0d want 1", level);
        end
        gameState = 2'b00; tick();
        gameState = 2'b01; tick();
        repeat (4) tick();
        reset = 1'b1; tick();
        vectors++;
        if (dut_bundle !== 212'd0) begin
            miscompares++; $display("FAIL reset_in_config: got %h want 0", dut_bundle);
        end
        reset = 1'b0; gameState = 2'b00; tick();
        vectors++;
        if (dut_bundle !== 212'd0) begin
            miscompares++; $display("FAIL reset_then_idle: got %h want 0", dut_bundle);
        end
    endtask

    task automatic test_random();
        int unsigned r;
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 199);
            if (r == 0) gameState = 2'b00;
            else if (r < 4) gameState = 2'b10;
            else if (r < 6) gameState = 2'b11;
            else if (r < 30) gameState = 2'b01;
            frame_start = ($urandom_range(0, 3) == 0);
            level_up_req = ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 999) == 0);
            tick();
            vectors++;
            if (dut_bundle !== expected_bundle()) begin
                miscompares++; $display("FAIL random_model c=%0d: got %h want %h", c, dut_bundle, expected_bundle());
            end
        end
        reset = 1'b0; frame_start = 1'b0; level_up_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_config();
        test_run_spawn();
        test_level_up();
        test_saturation();
        test_pause();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
